regfile_writeback: RTL and testbench

- Writer side of the 32x32 register file write port: `rd_we`, `writeReg[4:0]`, `writeData[31:0]`; the file writes on posedge and ignores x0.
- Accepts results from the ALU and LSU over valid/ready handshakes, buffers them in an in-order FIFO, and retires at most one write per cycle.
- Keeps a per-register pending scoreboard so decode can detect RAW hazards against writes not yet retired.
- Sits between execute/memory and the register file.

---
 rtl/regfile_writeback_if.sv | 61 ++++++
 rtl/regfile_writeback.sv | 121 ++++++++++++
 tb/tb_regfile_writeback.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: writeback bundle between execute/memory, decode and
// the register file write port.
//   alu_*/lsu_*        producer result handshakes (valid/ready, rd, data)
//   mark_*             decode issues a destination into the scoreboard
//   chk_rs*/hz_rs*     decode RAW hazard query
//   rd_we/writeReg/writeData  register file write port
//   fwd_rs*            same-cycle forward of the retiring write (WB_BYPASS_EN)
// slave: the writeback block. master: producers/decode/register file side.
interface regfile_writeback_if #(
  parameter int XLEN = 32
);
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            mark_valid, mark_ready;
  logic [4:0]      mark_rd;
  logic [4:0]      chk_rs1, chk_rs2;
  logic            hz_rs1, hz_rs2;
  logic            rd_we;
  logic [4:0]      writeReg;
  logic [XLEN-1:0] writeData;
`ifdef WB_BYPASS_EN
  logic            fwd_rs1_valid, fwd_rs2_valid;
  logic [XLEN-1:0] fwd_rs1_data, fwd_rs2_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  mark_valid, mark_rd,
    output mark_ready,
    input  chk_rs1, chk_rs2,
    output hz_rs1, hz_rs2,
    output rd_we, writeReg, writeData
`ifdef WB_BYPASS_EN
    ,
    output fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output mark_valid, mark_rd,
    input  mark_ready,
    output chk_rs1, chk_rs2,
    input  hz_rs1, hz_rs2,
    input  rd_we, writeReg, writeData
`ifdef WB_BYPASS_EN
    ,
    input  fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data
`endif
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: accepts ALU and LSU results, queues them in order and
// retires at most one register file write per cycle. A 2-bit per-register
// pending counter lets decode detect RAW hazards on unretired writes.
// Ports: clk, rst (synchronous, active-high), wb (regfile_writeback_if.slave).
// Optional: define WB_BYPASS_EN to add fwd_rs* outputs that forward the
// write currently presented to the register file.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_writeback_if.slave wb
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]       rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, free;
  logic             lsu_push, alu_push, pop, mark_acc;
  logic [1:0]       n_push;
  logic [31:0][1:0] cnt;
  logic [31:0]      inc_vec, dec_vec;

  // Readiness looks only at occupancy before this edge's pop, so a full
  // FIFO never accepts even though it drains one entry the same cycle.
  assign free         = DEPTH_C - count;
  assign wb.lsu_ready = (free != '0);
  assign wb.alu_ready = (free >= (AW+1)'(2)) || ((free != '0) && !wb.lsu_valid);

  // x0 results complete the handshake but never occupy a slot.
  assign lsu_push = wb.lsu_valid && wb.lsu_ready && (wb.lsu_rd != 5'd0);
  assign alu_push = wb.alu_valid && wb.alu_ready && (wb.alu_rd != 5'd0);
  assign n_push   = {1'b0, lsu_push} + {1'b0, alu_push};
  assign pop      = (count != '0);

  // LSU goes in first; ALU takes the following slot when both push.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      rd_mem[wr_ptr]   <= wb.lsu_rd;
      data_mem[wr_ptr] <= wb.lsu_data;
    end
    if (alu_push) begin
      rd_mem[wr_ptr + AW'(lsu_push)]   <= wb.alu_rd;
      data_mem[wr_ptr + AW'(lsu_push)] <= wb.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wb.rd_we     <= 1'b0;
      wb.writeReg  <= '0;
      wb.writeData <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      count  <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      if (pop) begin
        rd_ptr       <= rd_ptr + AW'(1);
        wb.rd_we     <= 1'b1;
        wb.writeReg  <= rd_mem[rd_ptr];
        wb.writeData <= data_mem[rd_ptr];
      end else begin
        wb.rd_we <= 1'b0;
      end
    end
  end

  // Scoreboard: count up on issue, down when the register file samples the
  // write (rd_we high at the edge). Both on one register cancel out.
  assign wb.mark_ready = (cnt[wb.mark_rd] != 2'd3) || (wb.mark_rd == 5'd0);
  assign mark_acc      = wb.mark_valid && wb.mark_ready && (wb.mark_rd != 5'd0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (mark_acc) inc_vec[wb.mark_rd]  = 1'b1;
    if (wb.rd_we) dec_vec[wb.writeReg] = 1'b1;
  end

  // cnt[0] is only ever cleared, so x0 never reads as pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != 2'd0)
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

`ifndef SYNTHESIS
  // A retire with nothing pending means a producer sent an unmarked rd.
  always_ff @(posedge clk) begin
    if (!rst && wb.rd_we)
      assert (cnt[wb.writeReg] != 2'd0);
  end
`endif

`ifdef WB_BYPASS_EN
  // The register file reads before it writes, so the retiring write is
  // forwarded and no longer counts as a hazard for that source.
  assign wb.fwd_rs1_valid = wb.rd_we && (wb.writeReg == wb.chk_rs1) && (wb.chk_rs1 != 5'd0);
  assign wb.fwd_rs2_valid = wb.rd_we && (wb.writeReg == wb.chk_rs2) && (wb.chk_rs2 != 5'd0);
  assign wb.fwd_rs1_data  = wb.writeData;
  assign wb.fwd_rs2_data  = wb.writeData;
  // cnt[x0] is 0 and forward is never valid for x0, so no explicit x0 term.
  assign wb.hz_rs1 = cnt[wb.chk_rs1] != {1'b0, wb.fwd_rs1_valid};
  assign wb.hz_rs2 = cnt[wb.chk_rs2] != {1'b0, wb.fwd_rs2_valid};
`else
  assign wb.hz_rs1 = (wb.chk_rs1 != 5'd0) && (cnt[wb.chk_rs1] != 2'd0);
  assign wb.hz_rs2 = (wb.chk_rs2 != 5'd0) && (cnt[wb.chk_rs2] != 2'd0);
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(XLEN)) wb ();
  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .wb(wb));

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of pending writes, an integer pending count per
  // register and the write currently presented to the register file.
  int          q_rd[$];
  logic [31:0] q_data[$];
  int          cnt[32];
  bit          m_we;
  int          m_wr;
  logic [31:0] m_wd;
  bit          acc_alu, acc_lsu, acc_mark;
  int          dut_log[$], mdl_log[$];
  int          pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_fwd(input int rs);
    return m_we && (m_wr == rs) && (rs != 0);
  endfunction

  function automatic bit exp_hz(input int rs);
    int c;
    c = cnt[rs];
`ifdef WB_BYPASS_EN
    if (exp_fwd(rs)) c = c - 1;
`endif
    return (rs != 0) && (c != 0);
  endfunction

  task automatic check_all();
    int fr;
    fr = DEPTH - q_rd.size();
    chk("lsu_ready", 32'(wb.lsu_ready), 32'(fr >= 1));
    chk("alu_ready", 32'(wb.alu_ready), 32'(fr >= 2 || (fr >= 1 && !wb.lsu_valid)));
    chk("mark_ready", 32'(wb.mark_ready), 32'(cnt[wb.mark_rd] != 3 || wb.mark_rd == 0));
    chk("hz_rs1", 32'(wb.hz_rs1), 32'(exp_hz(int'(wb.chk_rs1))));
    chk("hz_rs2", 32'(wb.hz_rs2), 32'(exp_hz(int'(wb.chk_rs2))));
    chk("rd_we", 32'(wb.rd_we), 32'(m_we));
    chk("writeReg", 32'(wb.writeReg), 32'(m_wr));
    chk("writeData", wb.writeData, m_wd);
`ifdef WB_BYPASS_EN
    chk("fwd_rs1_valid", 32'(wb.fwd_rs1_valid), 32'(exp_fwd(int'(wb.chk_rs1))));
    chk("fwd_rs2_valid", 32'(wb.fwd_rs2_valid), 32'(exp_fwd(int'(wb.chk_rs2))));
    if (exp_fwd(int'(wb.chk_rs1))) chk("fwd_rs1_data", wb.fwd_rs1_data, m_wd);
    if (exp_fwd(int'(wb.chk_rs2))) chk("fwd_rs2_data", wb.fwd_rs2_data, m_wd);
`endif
  endtask

  task automatic model_edge();
    bit li, ai, mi;
    int fr;
    fr = DEPTH - q_rd.size();
    li = wb.lsu_valid && fr >= 1;
    ai = wb.alu_valid && (fr >= 2 || (fr >= 1 && !wb.lsu_valid));
    mi = wb.mark_valid && wb.mark_rd != 0 && cnt[wb.mark_rd] != 3;
    if (rst) begin
      q_rd.delete();
      q_data.delete();
      foreach (cnt[i]) cnt[i] = 0;
      m_we = 0; m_wr = 0; m_wd = '0;
      acc_alu = 0; acc_lsu = 0; acc_mark = 0;
      return;
    end
    acc_lsu = li; acc_alu = ai; acc_mark = mi;
    if (mi) cnt[wb.mark_rd]++;
    if (m_we && cnt[m_wr] > 0) cnt[m_wr]--;
    if (q_rd.size() > 0) begin
      m_we = 1;
      m_wr = q_rd.pop_front();
      m_wd = q_data.pop_front();
      mdl_log.push_back(m_wr);
    end else begin
      m_we = 0;
    end
    if (li && wb.lsu_rd != 0) begin q_rd.push_back(int'(wb.lsu_rd)); q_data.push_back(wb.lsu_data); end
    if (ai && wb.alu_rd != 0) begin q_rd.push_back(int'(wb.alu_rd)); q_data.push_back(wb.alu_data); end
    if (mi) pend.push_back(int'(wb.mark_rd));
  endtask

  // One clock: check everything mid-cycle, then advance the model at the edge.
  task automatic step();
    @(negedge clk);
    check_all();
    if (wb.rd_we) dut_log.push_back(int'(wb.writeReg));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic mark(input int rd);
    wb.mark_valid = 1'b1;
    wb.mark_rd    = 5'(rd);
    step();
    wb.mark_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int li, ai, budget;
    bit saw_free1;
    wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
    wb.lsu_valid = 0; wb.lsu_rd = 0; wb.lsu_data = 0;
    wb.mark_valid = 0; wb.mark_rd = 0;
    wb.chk_rs1 = 0; wb.chk_rs2 = 0;
    foreach (cnt[i]) cnt[i] = 0;
    m_we = 0; m_wr = 0; m_wd = '0;

    // Reset
    rst = 1'b1;
    @(posedge clk); model_edge(); #1;
    step();
    chk("rst_rd_we", 32'(wb.rd_we), 32'd0);
    chk("rst_writeReg", 32'(wb.writeReg), 32'd0);
    chk("rst_writeData", wb.writeData, 32'd0);
    rst = 1'b0;

    // Mark x5, then ALU result for x5
    wb.chk_rs1 = 5'd5;
    mark(5);
    #1 chk("t1_hz_after_mark", 32'(wb.hz_rs1), 32'd1);
    wb.alu_valid = 1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
    #1 chk("t1_alu_ready", 32'(wb.alu_ready), 32'd1);
    step();
    wb.alu_valid = 0;
    #1 chk("t1_we_lat0", 32'(wb.rd_we), 32'd0);
    chk("t1_hz_queued", 32'(wb.hz_rs1), 32'd1);
    step();
    chk("t1_we", 32'(wb.rd_we), 32'd1);
    chk("t1_reg", 32'(wb.writeReg), 32'd5);
    chk("t1_data", wb.writeData, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    chk("t1_hz_retire_cycle", 32'(wb.hz_rs1), 32'd0);
`else
    chk("t1_hz_retire_cycle", 32'(wb.hz_rs1), 32'd1);
`endif
    step();
    chk("t1_hz_after", 32'(wb.hz_rs1), 32'd0);
    chk("t1_we_off", 32'(wb.rd_we), 32'd0);

    // Simultaneous LSU x3 and ALU x4
    wb.chk_rs1 = 5'd3; wb.chk_rs2 = 5'd4;
    mark(3); mark(4);
    wb.lsu_valid = 1; wb.lsu_rd = 5'd3; wb.lsu_data = 32'h11;
    wb.alu_valid = 1; wb.alu_rd = 5'd4; wb.alu_data = 32'h22;
    #1 chk("t2_lsu_ready", 32'(wb.lsu_ready), 32'd1);
    chk("t2_alu_ready", 32'(wb.alu_ready), 32'd1);
    step();
    wb.lsu_valid = 0; wb.alu_valid = 0;
    step();
    chk("t2_first_reg", 32'(wb.writeReg), 32'd3);
    chk("t2_first_data", wb.writeData, 32'h11);
    step();
    chk("t2_second_reg", 32'(wb.writeReg), 32'd4);
    chk("t2_second_data", wb.writeData, 32'h22);
    step();
    chk("t2_idle", 32'(wb.rd_we), 32'd0);

    // Continuous pushes from both producers
    for (int r = 10; r < 18; r++) mark(r);
    dut_log.delete(); mdl_log.delete();
    li = 0; ai = 0; budget = 0; saw_free1 = 0;
    while ((li < 4 || ai < 4) && budget < 40) begin
      wb.lsu_valid = (li < 4); wb.lsu_rd = 5'(10 + li); wb.lsu_data = 32'h100 + 32'(li);
      wb.alu_valid = (ai < 4); wb.alu_rd = 5'(14 + ai); wb.alu_data = 32'h200 + 32'(ai);
      #1;
      if (DEPTH - q_rd.size() == 1 && wb.lsu_valid) begin
        saw_free1 = 1;
        chk("t3_alu_ready_free1", 32'(wb.alu_ready), 32'd0);
      end
      step();
      if (acc_lsu) li++;
      if (acc_alu) ai++;
      budget++;
    end
    wb.lsu_valid = 0; wb.alu_valid = 0;
    chk("t3_all_accepted", 32'(li == 4 && ai == 4), 32'd1);
    chk("t3_saw_free1", 32'(saw_free1), 32'd1);
    repeat (6) step();
    chk("t3_retire_count", 32'(dut_log.size()), 32'd8);
    foreach (mdl_log[i])
      if (i < dut_log.size()) chk("t3_retire_order", 32'(dut_log[i]), 32'(mdl_log[i]));

    // ALU result to x0
    wb.alu_valid = 1; wb.alu_rd = 5'd0; wb.alu_data = 32'h99;
    #1 chk("t4_alu_ready", 32'(wb.alu_ready), 32'd1);
    step();
    wb.alu_valid = 0;
    step();
    chk("t4_no_we", 32'(wb.rd_we), 32'd0);
    step();
    chk("t4_no_we2", 32'(wb.rd_we), 32'd0);

    // x7 saturates; retire while a fourth mark is held
    wb.chk_rs1 = 5'd7;
    wb.mark_valid = 1; wb.mark_rd = 5'd7;
    repeat (3) step();
    chk("t5_mark_ready_low", 32'(wb.mark_ready), 32'd0);
    wb.alu_valid = 1; wb.alu_rd = 5'd7; wb.alu_data = 32'h77;
    step();
    wb.alu_valid = 0;
    step();
    chk("t5_retire_x7", 32'(wb.writeReg), 32'd7);
    chk("t5_mark_ready_retire", 32'(wb.mark_ready), 32'd0);
    step();
    chk("t5_mark_ready_after", 32'(wb.mark_ready), 32'd1);
    step();
    chk("t5_back_to_3", 32'(wb.mark_ready), 32'd0);
    wb.mark_valid = 0;
    wb.alu_valid = 1; wb.alu_rd = 5'd7;
    for (int k = 0; k < 3; k++) begin wb.alu_data = 32'h70 + 32'(k); step(); end
    wb.alu_valid = 0;
    repeat (4) step();
    chk("t5_hz_clear", 32'(wb.hz_rs1), 32'd0);

    // Reset mid-operation with three queued and x9 pending
    wb.chk_rs1 = 5'd9;
    mark(9); mark(20); mark(21); mark(22); mark(23);
    wb.lsu_valid = 1; wb.lsu_rd = 5'd20; wb.lsu_data = 32'h20;
    wb.alu_valid = 1; wb.alu_rd = 5'd21; wb.alu_data = 32'h21;
    step();
    wb.lsu_rd = 5'd22; wb.lsu_data = 32'h22;
    wb.alu_rd = 5'd23; wb.alu_data = 32'h23;
    step();
    wb.lsu_valid = 0; wb.alu_valid = 0;
    chk("t6_queued3", 32'(q_rd.size()), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("t6_rd_we", 32'(wb.rd_we), 32'd0);
    chk("t6_hz_x9", 32'(wb.hz_rs1), 32'd0);
    chk("t6_alu_ready", 32'(wb.alu_ready), 32'd1);
    repeat (3) step();
    chk("t6_stays_idle", 32'(wb.rd_we), 32'd0);

    // Forwarding of x9 in its retire cycle
    mark(9);
    wb.alu_valid = 1; wb.alu_rd = 5'd9; wb.alu_data = 32'h55;
    step();
    wb.alu_valid = 0;
    step();
    chk("t7_we_x9", 32'(wb.writeReg), 32'd9);
`ifdef WB_BYPASS_EN
    chk("t7_fwd_valid", 32'(wb.fwd_rs1_valid), 32'd1);
    chk("t7_fwd_data", wb.fwd_rs1_data, 32'h55);
    chk("t7_hz", 32'(wb.hz_rs1), 32'd0);
`else
    chk("t7_hz", 32'(wb.hz_rs1), 32'd1);
`endif
    step();

    // Random traffic; producers only send registers that were marked
    pend.delete();
    acc_alu = 0; acc_lsu = 0;
    for (int c = 0; c < 500; c++) begin
      if (acc_lsu) wb.lsu_valid = 0;
      if (acc_alu) wb.alu_valid = 0;
      if (!wb.lsu_valid && $urandom_range(0, 3) != 0) begin
        if (pend.size() > 0) begin
          wb.lsu_valid = 1; wb.lsu_rd = 5'(pend.pop_front()); wb.lsu_data = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          wb.lsu_valid = 1; wb.lsu_rd = 5'd0; wb.lsu_data = $urandom;
        end
      end
      if (!wb.alu_valid && $urandom_range(0, 3) != 0) begin
        if (pend.size() > 0) begin
          wb.alu_valid = 1; wb.alu_rd = 5'(pend.pop_front()); wb.alu_data = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          wb.alu_valid = 1; wb.alu_rd = 5'd0; wb.alu_data = $urandom;
        end
      end
      wb.mark_valid = 1'($urandom_range(0, 1));
      wb.mark_rd    = 5'($urandom_range(0, 7));
      wb.chk_rs1    = 5'($urandom_range(0, 7));
      wb.chk_rs2    = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
